// File: rtl/siso_shift_if.sv
// siso_shift_if: handshake / serial-link bundle for siso_shift_ctrl.
//  master : word producer and tick source (drives load_valid, load_data, shift_en)
//  slave  : the shift sequencer (drives load_ready, sout, busy, done, bit_cnt)
//  Signals:
//   load_valid/load_data/load_ready : parallel word handshake
//   shift_en                        : bit-advance tick
//   sout                            : serial output, LSB first
//   busy/done/bit_cnt               : frame status
interface siso_shift_if #(
   parameter int WIDTH = 4
);
   localparam int CNT_W = $clog2(WIDTH + 2);

   logic             load_valid;
   logic [WIDTH-1:0] load_data;
   logic             load_ready;
   logic             shift_en;
   logic             sout;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] bit_cnt;

   modport master (
      output load_valid, load_data, shift_en,
      input  load_ready, sout, busy, done, bit_cnt
   );

   modport slave (
      input  load_valid, load_data, shift_en,
      output load_ready, sout, busy, done, bit_cnt
   );
endinterface

// File: rtl/siso_shift_ctrl.sv
// siso_shift_ctrl: sequencer for a serial-in/serial-out right-shift datapath.
//  Takes a parallel word over a valid/ready handshake, then shifts it out
//  LSB-first on sout, one bit per shift_en tick, followed by a one-cycle done.
// Ports:
//  clk  : clock, all state updates on posedge
//  rst  : asynchronous, active-high reset
//  bus  : siso_shift_if.slave (load handshake, shift_en, sout, busy, done, bit_cnt)
// Parameters:
//  WIDTH : data bits per frame (>=1); bit_cnt width is derived from it
// Build option:
//  SISO_SHIFT_PARITY_EN : append one even-parity bit (^load_data) to each frame
module siso_shift_ctrl #(
   parameter int WIDTH = 4
) (
   input logic       clk,
   input logic       rst,
   siso_shift_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH + 2);
`ifdef SISO_SHIFT_PARITY_EN
   localparam int FRAME_LEN = WIDTH + 1;
`else
   localparam int FRAME_LEN = WIDTH;
`endif
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                 state;
   logic [FRAME_LEN-1:0]   shreg;
   logic [FRAME_LEN-1:0]   frame;
   logic [FRAME_LEN-1:0]   shreg_nx;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       cnt_nx;
   logic                   sout_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   ready_q;

   // Frame image captured at accept; parity rides above the data so the
   // same right shift delivers it last.
   always_comb begin
`ifdef SISO_SHIFT_PARITY_EN
      frame = {^bus.load_data, bus.load_data};
`else
      frame = bus.load_data;
`endif
      shreg_nx = shreg >> 1;
      cnt_nx   = cnt + CNT_W'(1);
   end

   // All outputs are registered; sout is loaded with the bit that will be
   // visible next, so there is no path from shift_en to sout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         shreg   <= '0;
         cnt     <= '0;
         sout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               // shift_en is ignored here, so a tick on the accepting edge
               // never shortens bit0.
               if (bus.load_valid && ready_q) begin
                  state   <= SHIFT;
                  shreg   <= frame;
                  cnt     <= '0;
                  sout_q  <= frame[0];
                  busy_q  <= 1'b1;
                  ready_q <= 1'b0;
               end
            end
            SHIFT: begin
               if (bus.shift_en) begin
                  shreg <= shreg_nx;
                  cnt   <= cnt_nx;
                  if (cnt_nx == LAST_CNT) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                     sout_q <= 1'b0;
                  end else begin
                     sout_q <= shreg_nx[0];
                  end
               end
            end
            DONE: begin
               state   <= IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               state   <= IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               sout_q  <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.load_ready = ready_q;
   assign bus.sout       = sout_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.bit_cnt    = cnt;
endmodule

// File: tb/tb_siso_shift_ctrl.sv
// tb_siso_shift_ctrl: directed bench for siso_shift_ctrl (WIDTH=4).
//  Inputs are driven and outputs sampled 1ns after each rising edge.
//  Define SISO_SHIFT_PARITY_EN for both bench and RTL to cover the parity frame.
module tb_siso_shift_ctrl;
   localparam int WIDTH = 4;
`ifdef SISO_SHIFT_PARITY_EN
   localparam int FL = WIDTH + 1;
`else
   localparam int FL = WIDTH;
`endif

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   siso_shift_if #(.WIDTH(WIDTH)) bus ();

   siso_shift_ctrl #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected transmitted bit k of word w (index WIDTH is the parity slot).
   function automatic logic fbit(input logic [WIDTH-1:0] w, input int k);
      logic [WIDTH:0] f;
      f = {^w, w};
      return f[k];
   endfunction

   // Load w with shift_en tied high; check every bit, done and return to IDLE.
   task automatic run_frame(input logic [WIDTH-1:0] w, input string tag);
      bus.load_valid = 1'b1;
      bus.load_data  = w;
      bus.shift_en   = 1'b1;
      tick();
      bus.load_valid = 1'b0;
      for (int k = 0; k < FL; k++) begin
         chk($sformatf("%s_sout%0d", tag, k), 32'(bus.sout), 32'(fbit(w, k)));
         chk($sformatf("%s_cnt%0d", tag, k), 32'(bus.bit_cnt), 32'(k));
         chk($sformatf("%s_nodone%0d", tag, k), 32'(bus.done), 32'd0);
         tick();
      end
      chk({tag, "_done"}, 32'(bus.done), 32'd1);
      chk({tag, "_done_busy"}, 32'(bus.busy), 32'd1);
      chk({tag, "_done_sout"}, 32'(bus.sout), 32'd0);
      chk({tag, "_done_rdy"}, 32'(bus.load_ready), 32'd0);
      chk({tag, "_done_cnt"}, 32'(bus.bit_cnt), 32'(FL));
      tick();
      chk({tag, "_idle_done"}, 32'(bus.done), 32'd0);
      chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_idle_rdy"}, 32'(bus.load_ready), 32'd1);
      bus.shift_en = 1'b0;
   endtask

   initial begin
      logic [WIDTH-1:0] w;
      rst            = 1'b1;
      bus.load_valid = 1'b0;
      bus.load_data  = '0;
      bus.shift_en   = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // 1: reset state
      chk("rst_sout", 32'(bus.sout), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_cnt", 32'(bus.bit_cnt), 32'd0);
      chk("rst_rdy", 32'(bus.load_ready), 32'd1);

      // 2: shift_en tied high, 1011 -> 1,1,0,1
      run_frame(4'b1011, "t2");

      // 3: shift_en every 3rd cycle, 0110 -> each bit held 3 cycles
      w = 4'b0110;
      bus.load_valid = 1'b1;
      bus.load_data  = w;
      bus.shift_en   = 1'b1;   // tick on the accepting edge must be ignored
      tick();
      bus.load_valid = 1'b0;
      for (int i = 1; i <= 3 * FL; i++) begin
         chk($sformatf("t3_sout_c%0d", i), 32'(bus.sout), 32'(fbit(w, (i - 1) / 3)));
         chk($sformatf("t3_cnt_c%0d", i), 32'(bus.bit_cnt), 32'((i - 1) / 3));
         chk($sformatf("t3_nodone_c%0d", i), 32'(bus.done), 32'd0);
         bus.shift_en = (i % 3 == 0);
         tick();
      end
      chk("t3_done", 32'(bus.done), 32'd1);
      chk("t3_done_cnt", 32'(bus.bit_cnt), 32'(FL));
      bus.shift_en = 1'b0;
      tick();
      chk("t3_idle", 32'(bus.load_ready), 32'd1);

      // 4: load_valid held across a busy frame; second word taken in first IDLE cycle
      bus.load_valid = 1'b1;
      bus.load_data  = 4'b1111;
      bus.shift_en   = 1'b1;
      tick();
      bus.load_data  = 4'b0001;
      for (int k = 0; k < FL; k++) begin
         chk($sformatf("t4a_sout%0d", k), 32'(bus.sout), 32'(fbit(4'b1111, k)));
         chk($sformatf("t4a_rdy%0d", k), 32'(bus.load_ready), 32'd0);
         tick();
      end
      chk("t4a_done", 32'(bus.done), 32'd1);
      tick();
      chk("t4_idle_rdy", 32'(bus.load_ready), 32'd1);
      chk("t4_idle_busy", 32'(bus.busy), 32'd0);
      tick();
      bus.load_valid = 1'b0;
      chk("t4b_busy", 32'(bus.busy), 32'd1);
      for (int k = 0; k < FL; k++) begin
         chk($sformatf("t4b_sout%0d", k), 32'(bus.sout), 32'(fbit(4'b0001, k)));
         chk($sformatf("t4b_cnt%0d", k), 32'(bus.bit_cnt), 32'(k));
         tick();
      end
      chk("t4b_done", 32'(bus.done), 32'd1);
      tick();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("t4_nodup%0d", i), 32'(bus.busy), 32'd0);
         tick();
      end
      bus.shift_en = 1'b0;

      // 5: reset mid-frame after two bits of 1010, then a clean 0011 frame
      bus.load_valid = 1'b1;
      bus.load_data  = 4'b1010;
      bus.shift_en   = 1'b1;
      tick();
      bus.load_valid = 1'b0;
      chk("t5_b0", 32'(bus.sout), 32'd0);
      tick();
      chk("t5_b1", 32'(bus.sout), 32'd1);
      tick();
      chk("t5_cnt2", 32'(bus.bit_cnt), 32'd2);
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_sout", 32'(bus.sout), 32'd0);
      chk("t5_rst_busy", 32'(bus.busy), 32'd0);
      chk("t5_rst_done", 32'(bus.done), 32'd0);
      chk("t5_rst_cnt", 32'(bus.bit_cnt), 32'd0);
      tick();
      rst = 1'b0;
      chk("t5_rdy", 32'(bus.load_ready), 32'd1);
      for (int i = 0; i < FL + 2; i++) begin
         chk($sformatf("t5_nodone%0d", i), 32'(bus.done), 32'd0);
         tick();
      end
      run_frame(4'b0011, "t5new");

`ifdef SISO_SHIFT_PARITY_EN
      // 6: parity frame, 0111 -> 1,1,1,0 then parity 1, done on +6
      run_frame(4'b0111, "t6");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
